// File: rtl/lighthouse_sensor_scheduler.sv
// Round-robin scheduler sharing one lighthouse pulse-duration unit across the sensor inputs.
// Optional pass-complete interrupt is built when LIGHTHOUSE_SCHED_IRQ_EN is defined.
module lighthouse_sensor_scheduler #(
    parameter int NUM_SENSORS    = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4:0]             address,
    input  logic                   write,
    input  logic [31:0]            writedata,
    input  logic                   read,
    output logic [31:0]            readdata,
    output logic                   waitrequest,
    input  logic [NUM_SENSORS-1:0] sensor_signal_i,
    output logic                   meas_sensor_o,
    output logic                   meas_start_o,
    input  logic                   meas_ready_i,
    input  logic [31:0]            meas_duration_i,
    output logic                   irq_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_ARM    = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_STORE  = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [2:0]             state;
    logic [3:0]             cur_ch;
    logic                   run;
    logic                   single;
    logic [NUM_SENSORS-1:0] enable;
    logic [NUM_SENSORS-1:0] valid;
    logic [NUM_SENSORS-1:0] timed_out;
    logic [31:0]            duration [NUM_SENSORS];
    logic [31:0]            store_val;
    logic                   store_tmo;
    logic [TW-1:0]          tmo_cnt;
    logic [SW-1:0]          settle_cnt;
    logic                   meas_sensor;
    logic                   irq;
    logic [4:0]             first_hit;
    logic [4:0]             next_hit;
    logic                   pass_done;
    logic                   run_nxt;
    logic                   unused_bits;

    // Returns {found, index} of the first set mask bit at from+first_off onwards, wrapping.
    function automatic logic [4:0] find_enabled(input logic [NUM_SENSORS-1:0] mask,
                                                input logic [3:0] from, input int first_off);
        logic       found;
        logic [3:0] idx;
        int         j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            j = int'(from) + k + first_off;
            if (j >= NUM_SENSORS) j = j - NUM_SENSORS;
            if (!found && mask[j[3:0]]) begin
                found = 1'b1;
                idx   = j[3:0];
            end
        end
        return {found, idx};
    endfunction

    assign first_hit   = find_enabled(enable, cur_ch, 0);
    assign next_hit    = find_enabled(enable, cur_ch, 1);
    // Landing on or before the current channel means the sweep wrapped.
    assign pass_done   = next_hit[4] && (next_hit[3:0] <= cur_ch);
    assign run_nxt     = (write && address == 5'd0) ? writedata[0] : run;
    assign waitrequest = 1'b0;
    assign meas_start_o  = (state == S_START);
    assign meas_sensor_o = meas_sensor;
    assign irq_o         = irq;
    assign unused_bits   = ^writedata[31:NUM_SENSORS];

    always_comb begin
        // NOTE: default assignment first keeps this block latch-free for unlisted addresses.
        readdata = 32'hDEAD_BEEF;
        case (address)
            5'd0: readdata = {30'b0, single, run};
            5'd1: readdata = 32'(enable);
            5'd2: readdata = {23'b0, state != S_IDLE, cur_ch, 4'b0};
            5'd3: readdata = 32'(valid);
            5'd4: readdata = 32'(timed_out);
`ifdef LIGHTHOUSE_SCHED_IRQ_EN
            5'd5: readdata = {31'b0, irq};
`endif
            default: begin
                if (address[4] && int'(address[3:0]) < NUM_SENSORS)
                    readdata = duration[address[3:0]];
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cur_ch      <= '0;
            run         <= 1'b0;
            single      <= 1'b0;
            enable      <= '0;
            valid       <= '0;
            timed_out   <= '0;
            store_val   <= '0;
            store_tmo   <= 1'b0;
            tmo_cnt     <= '0;
            settle_cnt  <= '0;
            meas_sensor <= 1'b0;
            // NOTE: results are reset too, so a DURATION read before any store returns 0.
            for (int n = 0; n < NUM_SENSORS; n++) duration[n] <= '0;
        end else begin
            // NOTE: non-blocking updates, so every branch below sees pre-edge register values.
            meas_sensor <= sensor_signal_i[cur_ch];

            if (write) begin
                case (address)
                    5'd0: begin
                        run    <= writedata[0];
                        single <= writedata[1];
                    end
                    5'd1: enable <= writedata[NUM_SENSORS-1:0];
                    5'd4: timed_out <= timed_out & ~writedata[NUM_SENSORS-1:0];
                    default: ;
                endcase
            end

            // Placed before the FSM so a same-cycle STORE to this slot overrides the clear.
            if (read && address[4] && int'(address[3:0]) < NUM_SENSORS)
                valid[address[3:0]] <= 1'b0;

            if (state != S_IDLE && !run_nxt) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run && enable != '0) begin
                            cur_ch     <= first_hit[3:0];
                            settle_cnt <= '0;
                            state      <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
                        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state <= S_START;
                        else settle_cnt <= settle_cnt + 1'b1;
                    end
                    S_START: begin
                        tmo_cnt <= '0;
                        state   <= S_ARM;
                    end
                    S_ARM, S_WAIT: begin
                        if (state == S_WAIT && meas_ready_i) begin
                            store_val <= meas_duration_i;
                            store_tmo <= 1'b0;
                            state     <= S_STORE;
                        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            store_val <= '1;
                            store_tmo <= 1'b1;
                            state     <= S_STORE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                            if (state == S_ARM && !meas_ready_i) state <= S_WAIT;
                        end
                    end
                    S_STORE: begin
                        duration[cur_ch] <= store_val;
                        valid[cur_ch]    <= 1'b1;
                        if (store_tmo) timed_out[cur_ch] <= 1'b1;
                        state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (next_hit[4]) cur_ch <= next_hit[3:0];
                        if (enable == '0 || !run) begin
                            state <= S_IDLE;
                        end else if (single && pass_done) begin
                            run   <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            settle_cnt <= '0;
                            state      <= S_SELECT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef LIGHTHOUSE_SCHED_IRQ_EN
    always_ff @(posedge clock) begin
        if (reset)                              irq <= 1'b0;
        else if (state == S_NEXT && pass_done)  irq <= 1'b1;
        else if (write && address == 5'd5)      irq <= 1'b0;
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: doc/lighthouse_sensor_scheduler.md
Name: lighthouse_sensor_scheduler

Overview:
Time-multiplexes one shared lighthouse pulse-duration measurement unit across up to 16 photodiode sensor inputs. Round-robin over an Avalon-programmable enable mask: select sensor, pulse start, wait for ready or timeout, store result per channel. Sits between the Avalon slave bus (HPS side) and the measurement unit, replacing the hard-wired single-sensor test hookup.

Parameters:
NUM_SENSORS, 16, number of sensor inputs / result slots (1..16)
TIMEOUT_CYCLES, 100000, clock cycles allowed per measurement before abort
SETTLE_CYCLES, 2, cycles between mux switch and start pulse (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  5  Avalon word address
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
read  in  1  Avalon read strobe
readdata  out  32  Avalon read data, combinational from address
waitrequest  out  1  Avalon wait; constant 0
sensor_signal_i  in  NUM_SENSORS  raw sensor inputs
meas_sensor_o  out  1  sensor_signal_i[cur_ch], registered
meas_start_o  out  1  one-cycle start pulse to measurement unit
meas_ready_i  in  1  measurement unit ready (level)
meas_duration_i  in  32  duration of last measured pulse
irq_o  out  1  pass-complete interrupt (see Optional Feature)

Behaviour:
- Reset: FSM=IDLE, cur_ch=0, all regs/results/valid/timeout flags=0, meas_start_o=0, meas_sensor_o=0, irq_o=0.
- Register map (read): 0 CTRL {30'b0, single, run}; 1 ENABLE [NUM_SENSORS-1:0]; 2 STATUS {busy[8], cur_ch[7:4], 4'b0}; 3 VALID mask; 4 TIMEOUT mask (sticky); 16+n DURATION[n]; others 32'hDEAD_BEEF.
- Writes: 0 CTRL, 1 ENABLE; 4 write-1-to-clear timeout bits; others ignored. Writes take effect next cycle.
- Reading 16+n (read=1) clears VALID[n]; a same-cycle store to n wins (VALID stays 1, new data).
- FSM: IDLE -> SELECT when run=1 and ENABLE!=0; picks lowest enabled channel >= cur_ch, wrapping.
- SELECT: meas_sensor_o follows channel; hold SETTLE_CYCLES -> START.
- START: meas_start_o=1 exactly one cycle; clear timeout counter -> ARM.
- ARM: wait meas_ready_i==0 (unit accepted start) -> WAIT.
- WAIT: meas_ready_i==1 -> STORE with duration.
- Timeout: counter runs in ARM and WAIT; when it reaches TIMEOUT_CYCLES -> STORE with 32'hFFFF_FFFF and TIMEOUT[ch] set.
- STORE (1 cycle): DURATION[ch]<=value, VALID[ch]<=1 -> NEXT.
- NEXT: next enabled channel strictly after cur_ch, wrapping mod NUM_SENSORS; wrap or single enabled channel counts as pass complete. If single=1 and pass complete: run<=0, -> IDLE. If ENABLE==0 or run==0: -> IDLE. Else -> SELECT.
- busy=1 in every state except IDLE.
- run cleared mid-measurement: abort at next cycle to IDLE, no store, meas_start_o=0.
- ENABLE changed mid-measurement: current channel completes; NEXT uses new mask.
- Reset mid-operation: immediate return to reset values, no pending store.

Optional Feature:
Macro LIGHTHOUSE_SCHED_IRQ_EN. Defined: irq_o sets on each pass-complete in NEXT, stays high until Avalon write of any value to address 5; set beats clear when simultaneous; reading address 5 returns {31'b0, irq_o}. Not defined: irq_o tied 0, address 5 reads 32'hDEAD_BEEF, writes ignored.

Test Plan:
- ENABLE=0x0005, CTRL=1, unit returns ready after 50 cycles with duration 123 -> channels 0,2 alternate; DURATION[0]=DURATION[2]=123, VALID=0x0005, one start pulse per measurement.
- ENABLE=0x8001, CTRL=3 (single) -> exactly channels 0 then 15 measured, CTRL reads 0x2, STATUS busy=0.
- ENABLE=0x0002, ready never asserts, TIMEOUT_CYCLES=100 -> DURATION[1]=0xFFFF_FFFF, TIMEOUT=0x0002 after ~100+SETTLE cycles; write 0x2 to addr 4 -> TIMEOUT=0.
- Read addr 17 in same cycle as STORE to ch1 -> VALID[1] remains 1, readdata shows old value.
- CTRL=0 written while in WAIT -> IDLE next cycle, no DURATION update; reset asserted mid-WAIT -> all registers 0.
- With LIGHTHOUSE_SCHED_IRQ_EN, ENABLE=0x0003, run -> irq_o rises after ch1 store; write addr 5 -> irq_o=0 next cycle.
